// File: rtl/ctrl_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 9-bit accumulator CPU.
// Enables are registered copies of the decode of the next state and next IR.
module ctrl_sequencer #(
  parameter int             IW        = 9,
  parameter int             OPW       = 3,
  parameter logic [OPW-1:0] OP_SHL    = 3'b001,
  parameter logic [OPW-1:0] OP_SHR    = 3'b010,
  parameter logic [OPW-1:0] OP_LOAD   = 3'b011,
  parameter logic [OPW-1:0] OP_MOV    = 3'b101,
  parameter logic [OPW-1:0] OP_BRANCH = 3'b110,
  parameter logic [OPW-1:0] OP_STORE  = 3'b111,
  parameter int             LOAD_LAT  = 1,
  parameter int             STORE_LAT = 1,
  parameter int             CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [IW-1:0]    Instruction,
  output logic             IrLoad,
  output logic             PcEn,
  output logic             BranchEn,
  output logic             MovEn,
  output logic             Shift,
  output logic             MemRdEn,
  output logic             MemWrEn,
  output logic             LoadInst,
  output logic             RegWrEn,
  output logic             Busy,
  output logic             Ack,
  output logic [CNT_W-1:0] InstCount
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam int MAX_LAT = (LOAD_LAT > STORE_LAT) ? LOAD_LAT : STORE_LAT;
  localparam int MCW     = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  // Bit order of the enable vector: {IrLoad,PcEn,BranchEn,MovEn,Shift,MemRdEn,MemWrEn,LoadInst,RegWrEn,Busy,Ack}
  localparam int B_IRL  = 10;
  localparam int B_PC   = 9;
  localparam int B_BR   = 8;
  localparam int B_MOV  = 7;
  localparam int B_SH   = 6;
  localparam int B_MRD  = 5;
  localparam int B_MWR  = 4;
  localparam int B_LI   = 3;
  localparam int B_RW   = 2;
  localparam int B_BUSY = 1;
  localparam int B_ACK  = 0;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [MCW-1:0]   memcnt_q, memcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      outs_q, outs_d;
  logic             retire_s;
  logic [OPW-1:0]   op_s;
  logic             halt_s;

  function automatic logic [10:0] decode_outs(input logic [2:0] st, input logic [IW-1:0] ir);
    logic [OPW-1:0] op;
    logic           hw;
    logic           is_ld;
    logic           is_st;
    logic           is_sh;
    logic           is_mv;
    logic [10:0]    o;
    op    = ir[IW-1 -: OPW];
    hw    = (ir == {IW{1'b1}});
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    is_sh = (op == OP_SHL) || (op == OP_SHR);
    is_mv = (op == OP_MOV);
    o     = 11'b0;
    case (st)
      S_FETCH: begin
        o[B_IRL]  = 1'b1;
        o[B_BUSY] = 1'b1;
      end
      S_DECODE: o[B_BUSY] = 1'b1;
      S_EXEC: begin
        o[B_BUSY] = 1'b1;
        o[B_PC]   = ~hw;
        o[B_BR]   = ~hw & (op == OP_BRANCH);
        o[B_MOV]  = ~hw & is_mv;
        o[B_SH]   = ~hw & is_sh;
      end
      S_MEM: begin
        o[B_BUSY] = 1'b1;
        o[B_MRD]  = ~hw & is_ld;
        o[B_MWR]  = ~hw & is_st;
      end
      S_WB: begin
        o[B_BUSY] = 1'b1;
        o[B_RW]   = ~hw;
        o[B_LI]   = ~hw & is_ld;
        o[B_MOV]  = ~hw & is_mv;
        o[B_SH]   = ~hw & is_sh;
      end
      S_HALT:  o[B_ACK] = 1'b1;
      default: o = 11'b0;
    endcase
    return o;
  endfunction

  assign op_s   = ir_q[IW-1 -: OPW];
  assign halt_s = (ir_q == {IW{1'b1}});

  // Next-state, IR capture, MEM latency counter and retire detection.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    memcnt_d = memcnt_q;
    retire_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        ir_d    = Instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (halt_s) state_d = S_HALT;
        else        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_s == OP_LOAD) begin
          state_d  = S_MEM;
          memcnt_d = MCW'(LOAD_LAT - 1);
        end else if (op_s == OP_STORE) begin
          state_d  = S_MEM;
          memcnt_d = MCW'(STORE_LAT - 1);
        end else if (op_s == OP_BRANCH) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        if (memcnt_q != {MCW{1'b0}}) begin
          memcnt_d = memcnt_q - {{(MCW-1){1'b0}}, 1'b1};
        end else if (op_s == OP_LOAD) begin
          state_d  = S_WB;
        end else begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_HALT: begin
        if (Start) state_d = S_FETCH;
        else       state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Retired-instruction counter: cleared on a fresh start from IDLE, saturates at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && Start) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (retire_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered enables so every output moves only on a clock edge.
  always_comb begin
    outs_d = decode_outs(state_d, ir_d);
  end

  // State, IR, counters and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      ir_q     <= {IW{1'b0}};
      memcnt_q <= {MCW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      outs_q   <= 11'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      memcnt_q <= memcnt_d;
      cnt_q    <= cnt_d;
      outs_q   <= outs_d;
    end
  end

  assign IrLoad    = outs_q[B_IRL];
  assign PcEn      = outs_q[B_PC];
  assign BranchEn  = outs_q[B_BR];
  assign MovEn     = outs_q[B_MOV];
  assign Shift     = outs_q[B_SH];
  assign MemRdEn   = outs_q[B_MRD];
  assign MemWrEn   = outs_q[B_MWR];
  assign LoadInst  = outs_q[B_LI];
  assign RegWrEn   = outs_q[B_RW];
  assign Busy      = outs_q[B_BUSY];
  assign Ack       = outs_q[B_ACK];
  assign InstCount = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: per-cycle expected enables are queued per instruction
// and compared at each falling edge against a 16-bit-counter and a 2-bit-counter instance.
module tb_ctrl_sequencer;

  localparam logic [10:0] IRL  = 11'b100_0000_0000;
  localparam logic [10:0] PCEN = 11'b010_0000_0000;
  localparam logic [10:0] BR   = 11'b001_0000_0000;
  localparam logic [10:0] MOV  = 11'b000_1000_0000;
  localparam logic [10:0] SH   = 11'b000_0100_0000;
  localparam logic [10:0] MRD  = 11'b000_0010_0000;
  localparam logic [10:0] MWR  = 11'b000_0001_0000;
  localparam logic [10:0] LI   = 11'b000_0000_1000;
  localparam logic [10:0] RW   = 11'b000_0000_0100;
  localparam logic [10:0] BUSY = 11'b000_0000_0010;
  localparam logic [10:0] ACK  = 11'b000_0000_0001;
  localparam int          LLAT = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [8:0]  Instruction;

  logic        a_irl, a_pc, a_br, a_mov, a_sh, a_mrd, a_mwr, a_li, a_rw, a_busy, a_ack;
  logic        b_irl, b_pc, b_br, b_mov, b_sh, b_mrd, b_mwr, b_li, b_rw, b_busy, b_ack;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;
  logic [10:0] a_outs, b_outs;

  assign a_outs = {a_irl, a_pc, a_br, a_mov, a_sh, a_mrd, a_mwr, a_li, a_rw, a_busy, a_ack};
  assign b_outs = {b_irl, b_pc, b_br, b_mov, b_sh, b_mrd, b_mwr, b_li, b_rw, b_busy, b_ack};

  ctrl_sequencer #(.LOAD_LAT(LLAT), .STORE_LAT(1), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .IrLoad(a_irl), .PcEn(a_pc), .BranchEn(a_br), .MovEn(a_mov), .Shift(a_sh),
    .MemRdEn(a_mrd), .MemWrEn(a_mwr), .LoadInst(a_li), .RegWrEn(a_rw),
    .Busy(a_busy), .Ack(a_ack), .InstCount(a_cnt)
  );

  ctrl_sequencer #(.LOAD_LAT(LLAT), .STORE_LAT(1), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
    .IrLoad(b_irl), .PcEn(b_pc), .BranchEn(b_br), .MovEn(b_mov), .Shift(b_sh),
    .MemRdEn(b_mrd), .MemWrEn(b_mwr), .LoadInst(b_li), .RegWrEn(b_rw),
    .Busy(b_busy), .Ack(b_ack), .InstCount(b_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          ph;
    logic [10:0] outs;
    int          cnt;
    logic        fetch;
    logic [8:0]  word;
    logic        start;
  } ent_t;

  ent_t sb_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   exp_cnt = 0;

  function automatic string ph_name(input int ph);
    case (ph)
      0: return "idle";
      1: return "fetch";
      2: return "decode";
      3: return "exec";
      4: return "mem";
      5: return "wb";
      6: return "halt";
      default: return "reset";
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int ph, input logic [10:0] o, input logic f,
                      input logic [8:0] w, input logic s);
    ent_t e;
    e.ph = ph; e.outs = o; e.cnt = exp_cnt; e.fetch = f; e.word = w; e.start = s;
    sb_q.push_back(e);
  endtask

  // Queue the cycle-by-cycle enables one instruction must produce, FETCH through retire.
  task automatic push_instr(input logic [8:0] w, input logic hold);
    logic [2:0]  op;
    logic [10:0] ex;
    op = w[8:6];
    push(1, IRL | BUSY, 1'b1, w, hold);
    push(2, BUSY, 1'b0, 9'h000, hold);
    if (w == 9'h1FF) return;
    ex = PCEN | BUSY;
    if (op == 3'b110) ex = ex | BR;
    if (op == 3'b101) ex = ex | MOV;
    if (op == 3'b001 || op == 3'b010) ex = ex | SH;
    push(3, ex, 1'b0, 9'h000, hold);
    if (op == 3'b011) begin
      for (int i = 0; i < LLAT; i++) push(4, MRD | BUSY, 1'b0, 9'h000, hold);
      push(5, RW | LI | BUSY, 1'b0, 9'h000, hold);
    end else if (op == 3'b111) begin
      push(4, MWR | BUSY, 1'b0, 9'h000, hold);
    end else if (op != 3'b110) begin
      push(5, RW | BUSY | (ex & (MOV | SH)), 1'b0, 9'h000, hold);
    end
    exp_cnt++;
  endtask

  task automatic push_halt(input int n, input logic resume);
    for (int i = 0; i < n; i++) push(6, ACK, 1'b0, 9'h000, resume && (i == n - 1));
  endtask

  task automatic drain(input int n);
    ent_t e;
    int   sat;
    for (int i = 0; i < n; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge Clk);
      e   = sb_q.pop_front();
      sat = (e.cnt > 3) ? 3 : e.cnt;
      check_eq($sformatf("%s outs", ph_name(e.ph)), {21'b0, a_outs}, {21'b0, e.outs});
      check_eq($sformatf("%s count", ph_name(e.ph)), {16'b0, a_cnt}, e.cnt);
      check_eq($sformatf("%s outs cw2", ph_name(e.ph)), {21'b0, b_outs}, {21'b0, e.outs});
      check_eq($sformatf("%s count cw2", ph_name(e.ph)), {30'b0, b_cnt}, sat);
      if (e.fetch) Instruction = e.word;
      Start = e.start;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " outs"}, {21'b0, a_outs}, 32'd0);
    check_eq({tag, " count"}, {16'b0, a_cnt}, 32'd0);
    check_eq({tag, " outs cw2"}, {21'b0, b_outs}, 32'd0);
    check_eq({tag, " count cw2"}, {30'b0, b_cnt}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    Instruction = 9'h000;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;

    push(0, 11'b0, 1'b0, 9'h000, 1'b1);
    push_instr(9'b001_000101, 1'b0);
    push_instr(9'b011_000011, 1'b0);
    push_instr(9'b111_000001, 1'b0);
    push_instr(9'b110_000100, 1'b1);
    push_instr(9'b101_010010, 1'b0);
    push_instr(9'b000_000111, 1'b0);
    push_instr(9'b100_111000, 1'b0);
    push_instr(9'b010_000001, 1'b0);
    push_instr(9'h1FF, 1'b0);
    push_halt(3, 1'b1);
    push_instr(9'b001_110011, 1'b1);
    push_instr(9'b101_000000, 1'b0);
    drain(sb_q.size());

    // Abort a load in its second MEM cycle.
    push_instr(9'b011_000001, 1'b0);
    drain(5);
    sb_q.delete();
    Reset = 1'b0;
    #1;
    check_all_zero("async reset");
    exp_cnt = 0;
    @(negedge Clk);
    check_all_zero("reset held");
    Reset = 1'b1;

    push(0, 11'b0, 1'b0, 9'h000, 1'b1);
    push_instr(9'b100_000001, 1'b0);
    push_instr(9'h1FF, 1'b0);
    push_halt(2, 1'b0);
    drain(sb_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
